// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM read path: response codes, window base,
// read-slave state encoding and the buffered beat format.
package vram_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] VRAM_BASE   = 32'h2000_0000;
  localparam int          FIFO_DEPTH  = 3;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } rd_state_t;

  typedef struct packed {
    logic        last;
    logic [1:0]  resp;
    logic [31:0] data;
  } beat_t;

endpackage

// File: rtl/vram_rd_fifo.sv
// Three-entry beat buffer between the RAM return path and the R channel.
// The head entry is presented directly so it stays stable while stalled.
module vram_rd_fifo
  import vram_pkg::*;
(
  input  logic       ACLK,
  input  logic       ARST,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count,
  output logic       empty
);

  beat_t      mem [FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/vram_axi_rdslave.sv
// AXI4 read-only slave serving fixed-length INCR bursts from a synchronous
// single-port VRAM with one cycle of read latency.
module vram_axi_rdslave
  import vram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = VRAM_BASE,
  parameter int          MEM_AW    = 18,
  parameter int          BURST_LEN = 64
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [31:0]       ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic              MEM_RE,
  input  logic [31:0]       MEM_RDATA
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  rd_state_t         state;
  rd_state_t         state_next;
  logic              arready_q;
  logic [MEM_AW-1:0] ptr;
  logic [CNT_W-1:0]  issue_cnt;
  logic              err;
  logic              inflight;
  logic              inflight_last;
  logic              issue;
  logic              ar_hs;
  logic              r_hs;
  beat_t             head;
  beat_t             push_beat;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^ARADDR[1:0];

  assign ar_hs = (state == ST_IDLE) && arready_q && ARVALID;
  assign r_hs  = !fifo_empty && RREADY;

  // Buffered plus in-flight words are capped at the FIFO depth, so every
  // issued read always has a slot waiting for it.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ar_hs) state_next = ST_BURST;
      end
      ST_BURST: begin
        issue = (issue_cnt < CNT_W'(BURST_LEN)) &&
                (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd3);
        if (r_hs && head.last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state         <= ST_IDLE;
      arready_q     <= 1'b0;
      ptr           <= '0;
      issue_cnt     <= '0;
      err           <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state     <= state_next;
      arready_q <= (state_next == ST_IDLE);
      if (ar_hs) begin
        ptr       <= ARADDR[MEM_AW+1:2];
        issue_cnt <= '0;
        err       <= (ARADDR[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]);
      end else if (issue) begin
        ptr       <= ptr + MEM_AW'(1);
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      inflight      <= issue;
      inflight_last <= issue && (issue_cnt == CNT_W'(BURST_LEN - 1));
    end
  end

  // Out-of-window bursts push zero words on the same schedule as real reads.
  always_comb begin
    push_beat.last = inflight_last;
    push_beat.resp = err ? RESP_SLVERR : RESP_OKAY;
    push_beat.data = err ? 32'h0 : MEM_RDATA;
  end

  vram_rd_fifo u_fifo (
    .ACLK      (ACLK),
    .ARST      (ARST),
    .push      (inflight),
    .push_beat (push_beat),
    .pop       (r_hs),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign ARREADY  = arready_q && !ARST;
  assign RVALID   = !fifo_empty && !ARST;
  assign RDATA    = ARST ? 32'h0 : head.data;
  assign RRESP    = ARST ? RESP_OKAY : head.resp;
  assign RLAST    = head.last && !ARST;
  assign MEM_RE   = issue && !err && !ARST;
  assign MEM_ADDR = ARST ? '0 : ptr;

endmodule

// File: tb/tb_vram_axi_rdslave.sv
// Directed bench for vram_axi_rdslave with a word-index RAM model that
// returns garbage whenever it was not read the cycle before.
module tb_vram_axi_rdslave;
  import vram_pkg::*;

  localparam int          MEM_AW    = 18;
  localparam int          BURST_LEN = 64;
  localparam logic [31:0] BASE      = 32'h2000_0000;

  logic              ACLK = 1'b0;
  logic              ARST;
  logic [31:0]       ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic [MEM_AW-1:0] MEM_ADDR;
  logic              MEM_RE;
  logic [31:0]       MEM_RDATA;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int reCount = 0;
  int outst = 0;
  int maxOut = 0;
  int lastWait = 0;
  logic [MEM_AW-1:0] reAddrs [$];

  vram_axi_rdslave #(
    .BASE_ADDR (BASE),
    .MEM_AW    (MEM_AW),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .ACLK      (ACLK),
    .ARST      (ARST),
    .ARADDR    (ARADDR),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_RE    (MEM_RE),
    .MEM_RDATA (MEM_RDATA)
  );

  always #5 ACLK = ~ACLK;

  // RAM word i holds i; unread cycles return a marker that must never surface.
  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    MEM_RDATA <= MEM_RE ? 32'(MEM_ADDR) : 32'hDEAD_BEEF;
    if (MEM_RE) begin
      reCount <= reCount + 1;
      reAddrs.push_back(MEM_ADDR);
    end
    if (ARST) outst <= 0;
    else outst <= outst + (MEM_RE ? 1 : 0) - ((RVALID && RREADY) ? 1 : 0);
    if (outst > maxOut) maxOut <= outst;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; runs one AR handshake and accepts stopAt beats.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] nextAddr,
                               input bit chain, input bit randReady,
                               input int stopAt, input string tag);
    logic [MEM_AW-1:0] w;
    logic [MEM_AW-1:0] wk;
    bit          err;
    int          n;
    int          beats;
    int          hsCyc;
    int          firstCyc;
    int          arBusy;
    int          reBefore;
    bit          stalled;
    logic [31:0] prevData;
    logic [1:0]  prevResp;
    logic        prevLast;
    logic [31:0] expData;

    w        = addr[MEM_AW+1:2];
    err      = (addr[31:MEM_AW+2] != BASE[31:MEM_AW+2]);
    reBefore = reCount;
    ARADDR   = addr;
    ARVALID  = 1'b1;
    n = 0;
    while (!ARREADY && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    lastWait = n;
    checkOutput({tag, ":arready"}, 32'(ARREADY), 32'd1);
    hsCyc = cyc;
    @(negedge ACLK);
    if (chain) ARADDR = nextAddr;
    else ARVALID = 1'b0;

    beats = 0; firstCyc = -1; arBusy = 0; stalled = 0; n = 0;
    prevData = '0; prevResp = '0; prevLast = 1'b0;
    while (beats < stopAt && n < 2000) begin
      if (ARREADY) arBusy++;
      RREADY = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (RVALID) begin
        if (firstCyc < 0) firstCyc = cyc;
        if (stalled) begin
          checkOutput($sformatf("%s:hold_data[%0d]", tag, beats), RDATA, prevData);
          checkOutput($sformatf("%s:hold_resp[%0d]", tag, beats), 32'(RRESP), 32'(prevResp));
          checkOutput($sformatf("%s:hold_last[%0d]", tag, beats), 32'(RLAST), 32'(prevLast));
        end
        if (RREADY) begin
          wk      = w + MEM_AW'(beats);
          expData = err ? 32'h0 : 32'(wk);
          checkOutput($sformatf("%s:data[%0d]", tag, beats), RDATA, expData);
          checkOutput($sformatf("%s:resp[%0d]", tag, beats), 32'(RRESP),
                      err ? 32'd2 : 32'd0);
          checkOutput($sformatf("%s:last[%0d]", tag, beats), 32'(RLAST),
                      (beats == BURST_LEN - 1) ? 32'd1 : 32'd0);
          beats++;
        end
      end
      stalled  = RVALID && !RREADY;
      prevData = RDATA;
      prevResp = RRESP;
      prevLast = RLAST;
      @(negedge ACLK);
      n++;
    end
    RREADY = 1'b1;
    checkOutput({tag, ":beats"}, 32'(beats), 32'(stopAt));
    checkOutput({tag, ":latency"}, 32'(firstCyc - hsCyc), 32'd3);
    checkOutput({tag, ":arready_busy"}, 32'(arBusy), 32'd0);
    if (stopAt == BURST_LEN) begin
      checkOutput({tag, ":arready_after"}, 32'(ARREADY), 32'd1);
      checkOutput({tag, ":mem_re_count"}, 32'(reCount - reBefore),
                  err ? 32'd0 : 32'(BURST_LEN));
    end
  endtask

  initial begin
    int idx;
    ARST = 1'b1; ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    $display("[TB] reset values");
    checkOutput("rst_arready", 32'(ARREADY), 32'd0);
    checkOutput("rst_rvalid", 32'(RVALID), 32'd0);
    checkOutput("rst_rlast", 32'(RLAST), 32'd0);
    checkOutput("rst_rresp", 32'(RRESP), 32'd0);
    checkOutput("rst_rdata", RDATA, 32'd0);
    checkOutput("rst_mem_re", 32'(MEM_RE), 32'd0);
    checkOutput("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
    ARST = 1'b0;
    @(negedge ACLK);
    checkOutput("idle_arready", 32'(ARREADY), 32'd1);

    $display("[TB] in-window burst");
    applyStimulus(BASE + 32'h100, '0, 1'b0, 1'b0, BURST_LEN, "inwin");

    $display("[TB] backpressure burst");
    applyStimulus(BASE + 32'h100, '0, 1'b0, 1'b1, BURST_LEN, "bp");
    checkOutput("bp_max_outstanding_le3", 32'(maxOut <= 3), 32'd1);

    $display("[TB] out-of-window burst");
    applyStimulus(32'h1000_0000, '0, 1'b0, 1'b0, BURST_LEN, "oow");

    $display("[TB] wrap burst");
    idx = reAddrs.size();
    applyStimulus(BASE + ((32'd1 << (MEM_AW + 2)) - 32'd8), '0, 1'b0, 1'b0, BURST_LEN, "wrap");
    checkOutput("wrap_addr0", 32'(reAddrs[idx]),     32'h3FFFE);
    checkOutput("wrap_addr1", 32'(reAddrs[idx + 1]), 32'h3FFFF);
    checkOutput("wrap_addr2", 32'(reAddrs[idx + 2]), 32'h00000);
    checkOutput("wrap_addr3", 32'(reAddrs[idx + 3]), 32'h00001);

    $display("[TB] back-to-back bursts");
    applyStimulus(BASE + 32'h000, BASE + 32'h1000, 1'b1, 1'b0, BURST_LEN, "b2b1");
    applyStimulus(BASE + 32'h1000, '0, 1'b0, 1'b0, BURST_LEN, "b2b2");
    checkOutput("b2b_handshake_wait", 32'(lastWait), 32'd0);

    $display("[TB] reset mid-burst");
    applyStimulus(BASE + 32'h400, '0, 1'b0, 1'b0, 10, "pre_rst");
    ARST = 1'b1;
    @(negedge ACLK);
    checkOutput("mid_rst_arready", 32'(ARREADY), 32'd0);
    checkOutput("mid_rst_rvalid", 32'(RVALID), 32'd0);
    checkOutput("mid_rst_rlast", 32'(RLAST), 32'd0);
    checkOutput("mid_rst_rresp", 32'(RRESP), 32'd0);
    checkOutput("mid_rst_rdata", RDATA, 32'd0);
    checkOutput("mid_rst_mem_re", 32'(MEM_RE), 32'd0);
    checkOutput("mid_rst_mem_addr", 32'(MEM_ADDR), 32'd0);
    ARST = 1'b0;
    @(negedge ACLK);
    checkOutput("post_rst_rvalid", 32'(RVALID), 32'd0);
    applyStimulus(BASE + 32'h800, '0, 1'b0, 1'b0, BURST_LEN, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
